// File: rtl/axis_rr_arbiter.sv
// Two-source AXI-Stream round-robin arbiter, bursts of up to C_BURST_LEN beats per grant.
// Latency: 1 cycle arbitration from IDLE, 1 cycle from accepted beat to registered output.
// Backpressure: granted tready = !m00_axis_tvalid || m00_axis_tready; non-granted tready is 0.
module axis_rr_arbiter #(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int C_BURST_LEN        = 4,
   parameter int C_CNT_WIDTH        = 8
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          cfg_enable,
   input  logic                          s00_axis_tvalid,
   output logic                          s00_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                          s01_axis_tvalid,
   output logic                          s01_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
   output logic                          m00_axis_tvalid,
   output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   input  logic                          m00_axis_tready,
   output logic [1:0]                    grant
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_G0   = 2'b01;
   localparam logic [1:0] ST_G1   = 2'b10;

   localparam logic [C_CNT_WIDTH-1:0] LAST_BEAT = C_CNT_WIDTH'(C_BURST_LEN - 1);

   logic [1:0]                    state;
   logic [1:0]                    state_nxt;
   logic                          last_grant;      // 1 = requester 1 owned the last grant
   logic                          last_grant_nxt;
   logic [C_CNT_WIDTH-1:0]        beat_cnt;
   logic                          out_free;
   logic                          acc0;
   logic                          acc1;
   logic                          accept;
   logic [C_AXIS_TDATA_WIDTH-1:0] acc_data;
   logic                          burst_end;
   logic                          rel0;
   logic                          rel1;

   assign grant     = state;
   assign out_free  = !m00_axis_tvalid || m00_axis_tready;
   assign burst_end = (beat_cnt == LAST_BEAT);

   // Ready depends only on ownership and output-register space, never on tvalid.
   always_comb begin
      s00_axis_tready = (state == ST_G0) && out_free;
      s01_axis_tready = (state == ST_G1) && out_free;
   end

   // Handshake detection and selection of the accepted beat.
   always_comb begin
      acc0     = s00_axis_tvalid && s00_axis_tready;
      acc1     = s01_axis_tvalid && s01_axis_tready;
      accept   = acc0 || acc1;
      acc_data = acc1 ? s01_axis_tdata : s00_axis_tdata;
   end

   // Release: burst completed, source went idle, or disabled while no beat moves.
   always_comb begin
      rel0 = (acc0 && burst_end) || !s00_axis_tvalid || (!cfg_enable && !acc0);
      rel1 = (acc1 && burst_end) || !s01_axis_tvalid || (!cfg_enable && !acc1);
   end

   // Next grant: round-robin on ties, direct hand-over to a waiting peer on release.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         ST_IDLE: begin
            if (cfg_enable) begin
               if (s00_axis_tvalid && s01_axis_tvalid) begin
                  state_nxt = last_grant ? ST_G0 : ST_G1;
               end else if (s00_axis_tvalid) begin
                  state_nxt = ST_G0;
               end else if (s01_axis_tvalid) begin
                  state_nxt = ST_G1;
               end
            end
         end
         ST_G0: begin
            if (rel0) begin
               last_grant_nxt = 1'b0;
               state_nxt      = (cfg_enable && s01_axis_tvalid) ? ST_G1 : ST_IDLE;
            end
         end
         ST_G1: begin
            if (rel1) begin
               last_grant_nxt = 1'b1;
               state_nxt      = (cfg_enable && s00_axis_tvalid) ? ST_G0 : ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Grant state, round-robin pointer and per-grant beat counter.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         if (state_nxt != state) begin
            beat_cnt <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + C_CNT_WIDTH'(1);
         end
      end
   end

   // Single output register: load on accept, clear valid once drained.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
      end else if (accept) begin
         m00_axis_tvalid <= 1'b1;
         m00_axis_tdata  <= acc_data;
      end else if (m00_axis_tready) begin
         m00_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, contention, single source, stall, early release, enable.
// Sources advance their data counter on each handshake; outputs logged on each downstream handshake.
// Inputs change 1 time unit after the rising edge; handshakes sampled on the falling edge.
module tb_axis_rr_arbiter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cfg_enable;
   logic        s0v, s0r, s1v, s1r;
   logic [31:0] s0d, s1d;
   logic        mv, mr;
   logic [31:0] md;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;
   int n0, n1, lim0;
   logic hs0, hs1;
   logic [31:0] outq[$];
   int glog[$];
   int vlog[$];
   int exp_g[$];
   int exp_v[$];
   logic [31:0] exp_o[$];

   always #5 aclk = ~aclk;

   axis_rr_arbiter #(
      .C_AXIS_TDATA_WIDTH(32),
      .C_BURST_LEN(4),
      .C_CNT_WIDTH(8)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .cfg_enable(cfg_enable),
      .s00_axis_tvalid(s0v),
      .s00_axis_tready(s0r),
      .s00_axis_tdata(s0d),
      .s01_axis_tvalid(s1v),
      .s01_axis_tready(s1r),
      .s01_axis_tdata(s1d),
      .m00_axis_tvalid(mv),
      .m00_axis_tdata(md),
      .m00_axis_tready(mr),
      .grant(grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at negedge, then advance sources after the edge.
   task automatic cyc();
      @(negedge aclk);
      hs0 = s0v && s0r;
      hs1 = s1v && s1r;
      if (mv && mr) outq.push_back(md);
      @(posedge aclk);
      #1;
      if (hs0) begin
         s0d = s0d + 1;
         n0++;
         if (n0 >= lim0) s0v = 1'b0;
      end
      if (hs1) begin
         s1d = s1d + 1;
         n1++;
      end
   endtask

   task automatic run_log(input int n);
      glog.delete();
      vlog.delete();
      for (int i = 0; i < n; i++) begin
         cyc();
         glog.push_back(int'(grant));
         vlog.push_back(int'(mv));
      end
   endtask

   task automatic do_reset();
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      s0v = 1'b0;
      s1v = 1'b0;
      mr = 1'b1;
      cfg_enable = 1'b1;
      s0d = 32'h100;
      s1d = 32'h200;
      n0 = 0;
      n1 = 0;
      lim0 = 1000;
      outq.delete();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   task automatic chk_out(input string tag);
      chk({tag, "_cnt"}, 32'(outq.size()), 32'(exp_o.size()));
      for (int i = 0; i < exp_o.size() && i < outq.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), outq[i], exp_o[i]);
   endtask

   task automatic chk_g(input string tag);
      for (int i = 0; i < exp_g.size(); i++)
         chk($sformatf("%s_grant%0d", tag, i), 32'(glog[i]), 32'(exp_g[i]));
   endtask

   task automatic chk_v(input string tag);
      for (int i = 0; i < exp_v.size(); i++)
         chk($sformatf("%s_tvalid%0d", tag, i), 32'(vlog[i]), 32'(exp_v[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset with both requesters valid
      aresetn = 1'b0;
      cfg_enable = 1'b1;
      s0v = 1'b1;
      s1v = 1'b1;
      s0d = 32'h100;
      s1d = 32'h200;
      mr = 1'b1;
      n0 = 0;
      n1 = 0;
      lim0 = 1000;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s0_tready", 32'(s0r), 32'h0);
      chk("rst_s1_tready", 32'(s1r), 32'h0);
      chk("rst_m_tvalid", 32'(mv), 32'h0);
      chk("rst_m_tdata", md, 32'h0);
      s1v = 1'b0;
      aresetn = 1'b1;
      cyc();
      chk("first_grant", 32'(grant), 32'h1);
      chk("first_s0_tready", 32'(s0r), 32'h1);
      chk("first_s1_tready", 32'(s1r), 32'h0);
      s0v = 1'b0;
      cyc();
      chk("idle_release_grant", 32'(grant), 32'h0);

      // Continuous contention
      do_reset();
      s0v = 1'b1;
      s1v = 1'b1;
      run_log(13);
      exp_g = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
      chk_g("cont");
      exp_o = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200, 32'h201,
                32'h202, 32'h203, 32'h104, 32'h105, 32'h106};
      chk_out("cont");

      // Single source, six beats
      do_reset();
      s0v = 1'b1;
      lim0 = 6;
      run_log(9);
      exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
      chk_g("single");
      exp_v = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
      chk_v("single");
      exp_o = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
      chk_out("single");

      // Backpressure for three cycles mid-burst
      do_reset();
      s0v = 1'b1;
      repeat (3) cyc();
      mr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall%0d_tdata", i), md, 32'h101);
         chk($sformatf("stall%0d_tvalid", i), 32'(mv), 32'h1);
         chk($sformatf("stall%0d_s0_tready", i), 32'(s0r), 32'h0);
         chk($sformatf("stall%0d_grant", i), 32'(grant), 32'h1);
         cyc();
      end
      chk("stall_end_tdata", md, 32'h101);
      mr = 1'b1;
      cyc();
      chk("stall_resume_grant", 32'(grant), 32'h1);
      chk("stall_resume_tdata", md, 32'h102);
      cyc();
      chk("stall_burst_end_grant", 32'(grant), 32'h0);
      s0v = 1'b0;
      repeat (2) cyc();
      exp_o = '{32'h100, 32'h101, 32'h102, 32'h103};
      chk_out("stall");

      // Early release hands over directly to the other requester
      do_reset();
      s0v = 1'b1;
      s1v = 1'b1;
      lim0 = 2;
      run_log(8);
      exp_g = '{1, 1, 1, 2, 2, 2, 2, 0};
      chk_g("early");
      s1v = 1'b0;
      repeat (2) cyc();
      exp_o = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h202, 32'h203};
      chk_out("early");

      // Reset mid-burst discards the registered beat
      do_reset();
      s0v = 1'b1;
      s1v = 1'b1;
      repeat (3) cyc();
      chk("mid_pre_tvalid", 32'(mv), 32'h1);
      chk("mid_pre_tdata", md, 32'h101);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_tvalid", 32'(mv), 32'h0);
      chk("mid_rst_tdata", md, 32'h0);
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_s0_tready", 32'(s0r), 32'h0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      cyc();
      chk("mid_after_grant", 32'(grant), 32'h1);

      // Enable low: no new grant, but a running burst is not cut mid-handshake
      do_reset();
      cfg_enable = 1'b0;
      s0v = 1'b1;
      cyc();
      chk("dis_idle_grant", 32'(grant), 32'h0);
      chk("dis_idle_s0_tready", 32'(s0r), 32'h0);
      cfg_enable = 1'b1;
      cyc();
      chk("en_grant", 32'(grant), 32'h1);
      cfg_enable = 1'b0;
      run_log(5);
      exp_g = '{1, 1, 1, 0, 0};
      chk_g("dis");
      exp_v = '{1, 1, 1, 1, 0};
      chk_v("dis");
      exp_o = '{32'h100, 32'h101, 32'h102, 32'h103};
      chk_out("dis");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
